// File: rtl/tlc_pkg.sv
// Shared types and constants for the traffic-light phase controller.
package tlc_pkg;

    // Controller phases. Encoding is fixed so the debug state output is stable.
    typedef enum logic [2:0] {
        ST_MAIN_GREEN  = 3'd0,
        ST_MAIN_YELLOW = 3'd1,
        ST_ALL_RED_A   = 3'd2,
        ST_WALK        = 3'd3,
        ST_SIDE_GREEN  = 3'd4,
        ST_SIDE_YELLOW = 3'd5,
        ST_ALL_RED_B   = 3'd6
    } tlc_state_t;

    // Lamp encodings, {R,Y,G} one-hot.
    localparam logic [2:0] LIGHT_RED = 3'b100;
    localparam logic [2:0] LIGHT_YEL = 3'b010;
    localparam logic [2:0] LIGHT_GRN = 3'b001;

    // Largest of the five dwell durations; sizes the dwell counter.
    function automatic int max_dwell(input int a, input int b, input int c,
                                     input int d, input int e);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        if (e > m) m = e;
        return m;
    endfunction

endpackage

// File: rtl/tlc_phase_controller_timer.sv
// Dwell timer: loads a duration on state entry and counts down on tick.
module tlc_dwell_timer #(
    parameter int              CW      = 3,
    parameter logic [CW-1:0]   RST_VAL = '0
) (
    input  logic          clk_in,
    input  logic          rst,
    input  logic          load_i,
    input  logic [CW-1:0] load_val_i,
    input  logic          tick_i,
    output logic [CW-1:0] count_o,
    output logic          expire_o
);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Next count: load wins, otherwise decrement on tick and hold at zero.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (tick_i && (count_q != '0)) begin
            count_d = count_q - CW'(1);
        end
    end

    // Count register, reset to the duration of the reset phase.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            count_q <= RST_VAL;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o  = count_q;
    assign expire_o = tick_i && (count_q == CW'(1));

endmodule

// File: rtl/tlc_phase_controller.sv
// Traffic-light phase sequencer: Moore FSM with latched side-road and
// pedestrian demand, tick-counted dwell times and registered lamp outputs.
module tlc_phase_controller
    import tlc_pkg::*;
#(
    parameter int GREEN_MAIN_MIN = 6,
    parameter int GREEN_SIDE     = 4,
    parameter int YELLOW         = 2,
    parameter int ALL_RED        = 1,
    parameter int WALK           = 3
) (
    input  logic       clk_in,
    input  logic       rst,
    input  logic       tick,
    input  logic       car_side,
    input  logic       ped_req,
    output logic [2:0] main_light,
    output logic [2:0] side_light,
    output logic       walk,
    output logic       ped_ack,
    output tlc_state_t state_o
);

    localparam int CW = $clog2(max_dwell(GREEN_MAIN_MIN, GREEN_SIDE, YELLOW,
                                         ALL_RED, WALK) + 1);

    if (GREEN_MAIN_MIN < 1 || GREEN_SIDE < 1 || YELLOW < 1 ||
        ALL_RED < 1 || WALK < 1) begin : g_bad_param
        $error("tlc_phase_controller: every dwell parameter must be >= 1");
    end

    tlc_state_t    state_q, state_d;
    logic          car_pending_q, car_pending_d;
    logic          ped_pending_q, ped_pending_d;
    logic [2:0]    main_light_q, main_light_d;
    logic [2:0]    side_light_q, side_light_d;
    logic          walk_q, walk_d;
    logic          load;
    logic [CW-1:0] load_val;
    logic [CW-1:0] count;
    logic          expire;
    logic          enter_side;
    logic          enter_walk;

    // Dwell length of a phase; MAIN_GREEN uses its minimum.
    function automatic logic [CW-1:0] dwell_of(input tlc_state_t s);
        case (s)
            ST_MAIN_GREEN:  return CW'(GREEN_MAIN_MIN);
            ST_MAIN_YELLOW: return CW'(YELLOW);
            ST_SIDE_YELLOW: return CW'(YELLOW);
            ST_WALK:        return CW'(WALK);
            ST_SIDE_GREEN:  return CW'(GREEN_SIDE);
            default:        return CW'(ALL_RED);
        endcase
    endfunction

    tlc_dwell_timer #(
        .CW      (CW),
        .RST_VAL (CW'(ALL_RED))
    ) u_timer (
        .clk_in     (clk_in),
        .rst        (rst),
        .load_i     (load),
        .load_val_i (load_val),
        .tick_i     (tick),
        .count_o    (count),
        .expire_o   (expire)
    );

    // Next phase; main green leaves only once its minimum is served and demand exists.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_MAIN_GREEN:  if (tick && (count <= CW'(1)) && (car_pending_q || ped_pending_q))
                                state_d = ST_MAIN_YELLOW;
            ST_MAIN_YELLOW: if (expire) state_d = ST_ALL_RED_A;
            ST_ALL_RED_A:   if (expire) state_d = ped_pending_q ? ST_WALK : ST_SIDE_GREEN;
            ST_WALK:        if (expire) state_d = car_pending_q ? ST_SIDE_GREEN : ST_ALL_RED_B;
            ST_SIDE_GREEN:  if (expire) state_d = ST_SIDE_YELLOW;
            ST_SIDE_YELLOW: if (expire) state_d = ST_ALL_RED_B;
            ST_ALL_RED_B:   if (expire) state_d = ST_MAIN_GREEN;
            default:        state_d = ST_ALL_RED_B;
        endcase
    end

    // Timer reload on every phase change, and demand latches where clear beats set.
    always_comb begin
        load          = (state_d != state_q);
        load_val      = dwell_of(state_d);
        enter_side    = (state_d == ST_SIDE_GREEN) && (state_q != ST_SIDE_GREEN);
        enter_walk    = (state_d == ST_WALK) && (state_q != ST_WALK);
        car_pending_d = (car_pending_q || car_side) && !enter_side;
        ped_pending_d = (ped_pending_q || ped_req) && !enter_walk;
    end

    // Lamp decode from the next phase so lamps switch on the same edge as the state.
    always_comb begin
        main_light_d = LIGHT_RED;
        side_light_d = LIGHT_RED;
        walk_d       = 1'b0;
        case (state_d)
            ST_MAIN_GREEN:  main_light_d = LIGHT_GRN;
            ST_MAIN_YELLOW: main_light_d = LIGHT_YEL;
            ST_SIDE_GREEN:  side_light_d = LIGHT_GRN;
            ST_SIDE_YELLOW: side_light_d = LIGHT_YEL;
            ST_WALK:        walk_d       = 1'b1;
            default:        ;
        endcase
    end

    // State, demand and lamp registers; reset forces all-red immediately.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_q       <= ST_ALL_RED_B;
            car_pending_q <= 1'b0;
            ped_pending_q <= 1'b0;
            main_light_q  <= LIGHT_RED;
            side_light_q  <= LIGHT_RED;
            walk_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            car_pending_q <= car_pending_d;
            ped_pending_q <= ped_pending_d;
            main_light_q  <= main_light_d;
            side_light_q  <= side_light_d;
            walk_q        <= walk_d;
        end
    end

    assign main_light = main_light_q;
    assign side_light = side_light_q;
    assign walk       = walk_q;
    assign ped_ack    = ped_pending_q;
    assign state_o    = state_q;

endmodule

// File: tb/tb_tlc_phase_controller.sv
// Scoreboard bench for tlc_phase_controller: the stimulus pushes the expected
// {main_light, side_light, walk, ped_ack} after each edge; a monitor pops and
// compares on the following falling edge.
module tb_tlc_phase_controller;
  import tlc_pkg::*;

  localparam logic [5:0] MG = {LIGHT_GRN, LIGHT_RED};
  localparam logic [5:0] MY = {LIGHT_YEL, LIGHT_RED};
  localparam logic [5:0] AR = {LIGHT_RED, LIGHT_RED};
  localparam logic [5:0] SG = {LIGHT_RED, LIGHT_GRN};
  localparam logic [5:0] SY = {LIGHT_RED, LIGHT_YEL};

  logic       clk_in = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       car_side = 1'b0;
  logic       ped_req = 1'b0;
  logic [2:0] main_light;
  logic [2:0] side_light;
  logic       walk;
  logic       ped_ack;
  tlc_state_t state_o;

  logic [7:0] exp_q[$];
  int         tag_q[$];
  int         step_no = 0;
  int         checks = 0;
  int         errors = 0;

  tlc_phase_controller dut (
    .clk_in     (clk_in),
    .rst        (rst),
    .tick       (tick),
    .car_side   (car_side),
    .ped_req    (ped_req),
    .main_light (main_light),
    .side_light (side_light),
    .walk       (walk),
    .ped_ack    (ped_ack),
    .state_o    (state_o)
  );

  // clock / reset
  always #5 clk_in = ~clk_in;

  function automatic logic [7:0] ex(input logic [5:0] l, input logic w, input logic a);
    return {l, w, a};
  endfunction

  // driver: apply inputs for one edge, then post the expected outputs
  task automatic cycle(input logic t, input logic c, input logic p, input logic [7:0] e);
    tick = t;
    car_side = c;
    ped_req = p;
    @(posedge clk_in);
    #1;
    exp_q.push_back(e);
    tag_q.push_back(step_no);
    step_no++;
  endtask

  task automatic run(input int n, input logic t, input logic [7:0] e);
    for (int i = 0; i < n; i++) cycle(t, 1'b0, 1'b0, e);
  endtask

  // reset with tick high; first edge after release enters main green
  task automatic do_reset();
    @(negedge clk_in);
    #1;
    rst = 1'b1;
    cycle(1'b1, 1'b0, 1'b0, ex(AR, 1'b0, 1'b0));
    cycle(1'b1, 1'b0, 1'b0, ex(AR, 1'b0, 1'b0));
    rst = 1'b0;
    cycle(1'b1, 1'b0, 1'b0, ex(MG, 1'b0, 1'b0));
  endtask

  // scoreboard monitor
  initial begin
    forever begin
      @(negedge clk_in);
      if (exp_q.size() > 0) begin
        logic [7:0] e;
        int id;
        e = exp_q.pop_front();
        id = tag_q.pop_front();
        checks++;
        if ({main_light, side_light, walk, ped_ack} !== e) begin
          errors++;
          $display("FAIL lights step %0d got main=%b side=%b walk=%b ack=%b exp main=%b side=%b walk=%b ack=%b",
                   id, main_light, side_light, walk, ped_ack, e[7:5], e[4:2], e[1], e[0]);
        end
      end
    end
  end

  // stimulus
  initial begin
    // reset and idle main green
    do_reset();
    run(100, 1'b1, ex(MG, 1'b0, 1'b0));

    // one-cycle car request during main green
    do_reset();
    cycle(1'b1, 1'b0, 1'b0, ex(MG, 1'b0, 1'b0));
    cycle(1'b1, 1'b1, 1'b0, ex(MG, 1'b0, 1'b0));
    run(3, 1'b1, ex(MG, 1'b0, 1'b0));
    run(2, 1'b1, ex(MY, 1'b0, 1'b0));
    run(1, 1'b1, ex(AR, 1'b0, 1'b0));
    run(4, 1'b1, ex(SG, 1'b0, 1'b0));
    run(2, 1'b1, ex(SY, 1'b0, 1'b0));
    run(1, 1'b1, ex(AR, 1'b0, 1'b0));
    run(8, 1'b1, ex(MG, 1'b0, 1'b0));

    // one-cycle pedestrian request
    do_reset();
    cycle(1'b1, 1'b0, 1'b1, ex(MG, 1'b0, 1'b1));
    run(4, 1'b1, ex(MG, 1'b0, 1'b1));
    run(2, 1'b1, ex(MY, 1'b0, 1'b1));
    run(1, 1'b1, ex(AR, 1'b0, 1'b1));
    run(3, 1'b1, ex(AR, 1'b1, 1'b0));
    run(1, 1'b1, ex(AR, 1'b0, 1'b0));
    run(5, 1'b1, ex(MG, 1'b0, 1'b0));

    // car and ped together; ped held into walk entry; car re-request in side green
    do_reset();
    cycle(1'b1, 1'b1, 1'b1, ex(MG, 1'b0, 1'b1));
    run(4, 1'b1, ex(MG, 1'b0, 1'b1));
    run(2, 1'b1, ex(MY, 1'b0, 1'b1));
    run(1, 1'b1, ex(AR, 1'b0, 1'b1));
    cycle(1'b1, 1'b0, 1'b1, ex(AR, 1'b1, 1'b0));
    run(2, 1'b1, ex(AR, 1'b1, 1'b0));
    run(1, 1'b1, ex(SG, 1'b0, 1'b0));
    cycle(1'b1, 1'b1, 1'b0, ex(SG, 1'b0, 1'b0));
    run(2, 1'b1, ex(SG, 1'b0, 1'b0));
    run(2, 1'b1, ex(SY, 1'b0, 1'b0));
    run(1, 1'b1, ex(AR, 1'b0, 1'b0));
    run(6, 1'b1, ex(MG, 1'b0, 1'b0));
    run(2, 1'b1, ex(MY, 1'b0, 1'b0));
    run(1, 1'b1, ex(AR, 1'b0, 1'b0));
    run(1, 1'b1, ex(SG, 1'b0, 1'b0));

    // slow tick (every 10th cycle) with a car request
    do_reset();
    for (int k = 1; k <= 115; k++) begin
      logic [7:0] e;
      if (k < 60)      e = ex(MG, 1'b0, 1'b0);
      else if (k < 80) e = ex(MY, 1'b0, 1'b0);
      else if (k < 90) e = ex(AR, 1'b0, 1'b0);
      else             e = ex(SG, 1'b0, 1'b0);
      cycle((k % 10) == 0, k == 1, 1'b0, e);
    end

    // asynchronous reset in the middle of side green
    @(negedge clk_in);
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if ({main_light, side_light, walk} !== {AR, 1'b0}) begin
      errors++;
      $display("FAIL async_rst got main=%b side=%b walk=%b exp main=%b side=%b walk=0",
               main_light, side_light, walk, LIGHT_RED, LIGHT_RED);
    end
    cycle(1'b0, 1'b0, 1'b0, ex(AR, 1'b0, 1'b0));
    cycle(1'b0, 1'b0, 1'b0, ex(AR, 1'b0, 1'b0));
    rst = 1'b0;
    run(3, 1'b0, ex(AR, 1'b0, 1'b0));
    cycle(1'b0, 1'b0, 1'b1, ex(AR, 1'b0, 1'b1));
    cycle(1'b1, 1'b0, 1'b0, ex(MG, 1'b0, 1'b1));
    run(5, 1'b1, ex(MG, 1'b0, 1'b1));
    run(1, 1'b1, ex(MY, 1'b0, 1'b1));

    // final report
    @(negedge clk_in);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending expectations exp 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
